vga_scan_ctrl: RTL and testbench

//  Parametrised VGA scan controller sitting between the processor's framebuffer

---
 rtl/vga_scan_ctrl_if.sv | 16 +
 rtl/vga_scan_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vga_scan_ctrl_if.sv
// Framebuffer read bus between the VGA scan controller and the framebuffer memory.
//   fb_rd_en : one-clk read strobe, issued by the scan controller
//   fb_addr  : framebuffer word address, issued by the scan controller
//   fb_data  : read data, returned by the memory a fixed number of pixel ticks later
// The master modport is the scan controller; the slave modport is the memory.
interface vga_scan_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int PIX_W  = 8
);
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_addr;
  logic [PIX_W-1:0]  fb_data;

  modport master (output fb_rd_en, output fb_addr, input fb_data);
  modport slave  (input fb_rd_en, input fb_addr, output fb_data);
endinterface

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: divides clk into a pixel tick and generates H/V timing,
// framebuffer read addresses (double-buffered, the buffer is chosen at frame
// boundaries only), and colour expansion to the 8-bit-per-channel DAC.
// Sync and blank are delayed by MEM_LAT ticks so they line up with read data.
// Ports:
//   clk, reset (sync, active-low)   switch : async buffer select request
//   fb (master)  : framebuffer read bus (fb_rd_en, fb_addr, fb_data)
//   frame_start  : one-clk pulse on the last tick of every frame
//   fb_sel       : buffer currently scanned
//   vgaclk, hsync, vsync, sync_b, blank_b, red, green, blue : DAC pins
module vga_scan_ctrl #(
  parameter int H_ACT      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACT      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int CLK_DIV    = 2,
  parameter int MEM_LAT    = 1,
  parameter int COLOR_MODE = 1,
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   switch,
  vga_scan_ctrl_if.master        fb,
  output logic                   frame_start,
  output logic                   fb_sel,
  output logic                   vgaclk,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   sync_b,
  output logic                   blank_b,
  output logic [7:0]             red,
  output logic [7:0]             green,
  output logic [7:0]             blue
);
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(H_ACT * V_ACT);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [HC_W-1:0]    hcnt_q, hcnt_d;
  logic [VC_W-1:0]    vcnt_q, vcnt_d;
  logic [ADDR_W-1:0]  lin_q, lin_d;
  logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
  logic               fb_rd_en_q, fb_rd_en_d;
  logic               frame_start_q, frame_start_d;
  logic               fb_sel_q, fb_sel_d;
  logic               vgaclk_q, vgaclk_d;
  logic               sw_meta_q, sw_sync_q;
  logic [MEM_LAT-1:0] act_pipe_q, act_pipe_d;
  logic [MEM_LAT-1:0] hs_pipe_q, hs_pipe_d;
  logic [MEM_LAT-1:0] vs_pipe_q, vs_pipe_d;
  logic               blank_q, blank_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic [23:0]        rgb_q, rgb_d;

  logic               tick_s, pre_tick_s, last_h_s, last_v_s;
  logic               act0_s, hs0_s, vs0_s;
  logic [PIX_W-1:0]   pix_raw_s;

  // Maps one framebuffer word to 24-bit RGB; narrower words arrive zero-extended.
  function automatic logic [23:0] expand_color(input logic [23:0] px);
    logic [23:0] rgb;
    case (COLOR_MODE)
      32'd0:   rgb = {px[7:0], px[7:0], px[7:0]};
      32'd1:   rgb = {px[7:5], px[7:5], px[7:6],
                      px[4:2], px[4:2], px[4:3],
                      {4{px[1:0]}}};
      32'd2:   rgb = px[23:0];
      default: rgb = 24'h00_0000;
    endcase
    return rgb;
  endfunction

  assign tick_s     = (div_q == DIV_W'(CLK_DIV - 1));
  // Registered strobes are computed one clk early so they sit exactly on the tick clk.
  assign pre_tick_s = (div_q == DIV_W'(CLK_DIV - 2));
  assign last_h_s   = (hcnt_q == HC_W'(H_TOTAL - 1));
  assign last_v_s   = (vcnt_q == VC_W'(V_TOTAL - 1));
  assign act0_s     = (hcnt_q < HC_W'(H_ACT)) && (vcnt_q < VC_W'(V_ACT));
  assign hs0_s      = (hcnt_q >= HC_W'(H_ACT + H_FP)) &&
                      (hcnt_q <= HC_W'(H_ACT + H_FP + H_SYNC - 1));
  assign vs0_s      = (vcnt_q >= VC_W'(V_ACT + V_FP)) &&
                      (vcnt_q <= VC_W'(V_ACT + V_FP + V_SYNC - 1));
  assign pix_raw_s  = fb.fb_data;

  // Next-state logic for the divider, scan counters, read strobe and output pipe.
  always_comb begin
    div_d         = div_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    lin_d         = lin_q;
    fb_sel_d      = fb_sel_q;
    act_pipe_d    = act_pipe_q;
    hs_pipe_d     = hs_pipe_q;
    vs_pipe_d     = vs_pipe_q;
    blank_d       = blank_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    rgb_d         = rgb_q;
    fb_rd_en_d    = pre_tick_s && act0_s;
    frame_start_d = pre_tick_s && last_h_s && last_v_s;
    fb_addr_d     = fb_addr_q;

    if (fb_rd_en_d) begin
      fb_addr_d = (fb_sel_q ? BUF1_BASE : {ADDR_W{1'b0}}) + lin_q;
    end else begin
      fb_addr_d = fb_addr_q;
    end

    if (tick_s) begin
      div_d = {DIV_W{1'b0}};
      if (last_h_s) begin
        hcnt_d = {HC_W{1'b0}};
        vcnt_d = last_v_s ? {VC_W{1'b0}} : vcnt_q + VC_W'(1);
      end else begin
        hcnt_d = hcnt_q + HC_W'(1);
        vcnt_d = vcnt_q;
      end
      // Buffer choice and the linear address restart together at the frame edge.
      if (last_h_s && last_v_s) begin
        lin_d    = {ADDR_W{1'b0}};
        fb_sel_d = sw_sync_q;
      end else if (act0_s) begin
        lin_d    = lin_q + ADDR_W'(1);
        fb_sel_d = fb_sel_q;
      end else begin
        lin_d    = lin_q;
        fb_sel_d = fb_sel_q;
      end
      // Oldest pipe stage meets the data read MEM_LAT ticks ago.
      blank_d    = act_pipe_q[MEM_LAT-1];
      hsync_d    = hs_pipe_q[MEM_LAT-1] ? H_POL : ~H_POL;
      vsync_d    = vs_pipe_q[MEM_LAT-1] ? V_POL : ~V_POL;
      rgb_d      = act_pipe_q[MEM_LAT-1] ? expand_color(24'(pix_raw_s)) : 24'h00_0000;
      act_pipe_d = MEM_LAT'({act_pipe_q, act0_s});
      hs_pipe_d  = MEM_LAT'({hs_pipe_q, hs0_s});
      vs_pipe_d  = MEM_LAT'({vs_pipe_q, vs0_s});
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    vgaclk_d = (div_d >= DIV_W'(CLK_DIV / 2));
  end

  // State register with synchronous active-low reset, including the switch synchroniser.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q         <= {DIV_W{1'b0}};
      hcnt_q        <= {HC_W{1'b0}};
      vcnt_q        <= {VC_W{1'b0}};
      lin_q         <= {ADDR_W{1'b0}};
      fb_addr_q     <= {ADDR_W{1'b0}};
      fb_rd_en_q    <= 1'b0;
      frame_start_q <= 1'b0;
      fb_sel_q      <= 1'b0;
      vgaclk_q      <= 1'b0;
      sw_meta_q     <= 1'b0;
      sw_sync_q     <= 1'b0;
      act_pipe_q    <= {MEM_LAT{1'b0}};
      hs_pipe_q     <= {MEM_LAT{1'b0}};
      vs_pipe_q     <= {MEM_LAT{1'b0}};
      blank_q       <= 1'b0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      rgb_q         <= 24'h00_0000;
    end else begin
      div_q         <= div_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      lin_q         <= lin_d;
      fb_addr_q     <= fb_addr_d;
      fb_rd_en_q    <= fb_rd_en_d;
      frame_start_q <= frame_start_d;
      fb_sel_q      <= fb_sel_d;
      vgaclk_q      <= vgaclk_d;
      sw_meta_q     <= switch;
      sw_sync_q     <= sw_meta_q;
      act_pipe_q    <= act_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      blank_q       <= blank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
    end
  end

  assign fb.fb_rd_en  = fb_rd_en_q;
  assign fb.fb_addr   = fb_addr_q;
  assign frame_start  = frame_start_q;
  assign fb_sel       = fb_sel_q;
  assign vgaclk       = vgaclk_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign sync_b       = 1'b0;
  assign blank_b      = blank_q;
  assign red          = rgb_q[23:16];
  assign green        = rgb_q[15:8];
  assign blue         = rgb_q[7:0];
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl on a small 14x7 timing (8x4 visible).
// dut0: MEM_LAT=1, RGB332, memory returns a hash of the address.
// dut1: MEM_LAT=3, RGB888, memory returns constant 24'h123456.
// Cycle c counts clks since reset release; tick clks are odd c, pixel t=(c-1)/2.
module tb_vga_scan_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic switch = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   sel_tab [0:7];

  always #5 clk = ~clk;

  vga_scan_ctrl_if #(.ADDR_W(8), .PIX_W(8))  fb0 ();
  vga_scan_ctrl_if #(.ADDR_W(8), .PIX_W(24)) fb1 ();

  logic fs0, sel0, vck0, hs0, vs0, sb0, bl0;
  logic fs1, sel1, vck1, hs1, vs1, sb1, bl1;
  logic [7:0] r0, g0, b0, r1, g1, b1;

  vga_scan_ctrl #(.H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                  .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                  .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(2), .MEM_LAT(1),
                  .COLOR_MODE(1), .PIX_W(8), .ADDR_W(8)) dut0 (
    .clk(clk), .reset(reset), .switch(switch), .fb(fb0),
    .frame_start(fs0), .fb_sel(sel0), .vgaclk(vck0), .hsync(hs0), .vsync(vs0),
    .sync_b(sb0), .blank_b(bl0), .red(r0), .green(g0), .blue(b0));

  vga_scan_ctrl #(.H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                  .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                  .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(2), .MEM_LAT(3),
                  .COLOR_MODE(2), .PIX_W(24), .ADDR_W(8)) dut1 (
    .clk(clk), .reset(reset), .switch(switch), .fb(fb1),
    .frame_start(fs1), .fb_sel(sel1), .vgaclk(vck1), .hsync(hs1), .vsync(vs1),
    .sync_b(sb1), .blank_b(bl1), .red(r1), .green(g1), .blue(b1));

  function automatic logic [7:0] memf(input logic [7:0] a);
    return a * 8'd37 + 8'd5;
  endfunction

  function automatic logic [23:0] rgb332(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], d[1:0], d[1:0], d[1:0], d[1:0]};
  endfunction

  // Latency-1 memory for dut0; fb1 data is constant.
  always @(posedge clk) if (fb0.fb_rd_en) fb0.fb_data <= memf(fb0.fb_addr);
  assign fb1.fb_data = 24'h123456;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_rd_en",  32'(fb0.fb_rd_en), 32'd0);
    chk("rst_addr",   32'(fb0.fb_addr),  32'd0);
    chk("rst_fs",     32'(fs0),  32'd0);
    chk("rst_sel",    32'(sel0), 32'd0);
    chk("rst_vgaclk", 32'(vck0), 32'd0);
    chk("rst_blank",  32'(bl0),  32'd0);
    chk("rst_rgb",    32'({r0, g0, b0}), 32'd0);
    chk("rst_hsync",  32'(hs0),  32'd1);
    chk("rst_vsync",  32'(vs0),  32'd1);
    chk("rst_blank1", 32'(bl1),  32'd0);
    chk("rst_rgb1",   32'({r1, g1, b1}), 32'd0);
    chk("rst_hsync1", 32'(hs1),  32'd1);
  endtask

  // Expected pin values of a pixel t: {blank, hsync, vsync} plus colour.
  task automatic pix_exp(input int t, input bit rgb888, output logic [2:0] bhv,
                         output logic [23:0] rgb);
    int n, h, v, f;
    logic [7:0] a;
    n = t % 98; h = n % 14; v = n / 14; f = t / 98;
    bhv = {(h < 8 && v < 4), !(h >= 10 && h <= 11), !(v == 5)};
    a = 8'(sel_tab[f] * 32 + v * 8 + h);
    if (!bhv[2]) rgb = 24'h0;
    else if (rgb888) rgb = 24'h123456;
    else rgb = rgb332(memf(a));
  endtask

  task automatic check_cycle(input int c);
    int t, n, h, v, f;
    logic [2:0] bhv;
    logic [23:0] rgb;
    if (c % 2 == 1) begin
      t = (c - 1) / 2; n = t % 98; h = n % 14; v = n / 14; f = t / 98;
      chk("fb_rd_en", 32'(fb0.fb_rd_en), 32'(h < 8 && v < 4));
      if (h < 8 && v < 4) chk("fb_addr", 32'(fb0.fb_addr), 32'(sel_tab[f] * 32 + v * 8 + h));
      chk("frame_start", 32'(fs0), 32'(n == 97));
    end else begin
      chk("fb_rd_en_gap", 32'(fb0.fb_rd_en), 32'd0);
      chk("frame_start_gap", 32'(fs0), 32'd0);
    end
    chk("vgaclk", 32'(vck0), 32'(c % 2));
    chk("fb_sel", 32'(sel0), 32'(sel_tab[c / 196]));
    chk("sync_b", 32'(sb0), 32'd0);
    if (c >= 4) pix_exp((c - 4) / 2, 1'b0, bhv, rgb);
    else begin bhv = 3'b011; rgb = 24'h0; end
    chk("pins0", 32'({bl0, hs0, vs0}), 32'(bhv));
    chk("rgb0", 32'({r0, g0, b0}), 32'(rgb));
    if (c >= 8) pix_exp((c - 8) / 2, 1'b1, bhv, rgb);
    else begin bhv = 3'b011; rgb = 24'h0; end
    chk("pins1", 32'({bl1, hs1, vs1}), 32'(bhv));
    chk("rgb1", 32'({r1, g1, b1}), 32'(rgb));
  endtask

  initial begin
    sel_tab = '{0, 0, 1, 1, 1, 1, 1, 1};
    // Reset held, then released at a falling edge (c=0).
    repeat (3) @(negedge clk);
    chk_reset();
    reset = 1'b1;
    // Four full frames plus part of a fifth; switch requests arrive mid-frame only.
    for (int c = 1; c <= 851; c++) begin
      @(negedge clk);
      check_cycle(c);
      case (c)
        250, 303, 340, 455, 480: switch = 1'b1;
        300, 320, 450, 470:      switch = 1'b0;
        default: ;
      endcase
    end
    // c=851 is the tick of hcnt=5, vcnt=2 in frame 4: reset mid-frame with fb_sel=1.
    chk("presel", 32'(sel0), 32'd1);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_reset();
    end
    reset = 1'b1;
    // switch stays 1: buffer 0 for the restarted frame, buffer 1 from the next one.
    sel_tab = '{0, 1, 1, 1, 1, 1, 1, 1};
    for (int c = 1; c <= 260; c++) begin
      @(negedge clk);
      check_cycle(c);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
